gpio_irq_ctrl: RTL and testbench
================================

// Module: gpio_irq_ctrl
// PURPOSE
//   Interrupt responder for the GPIO bank: one INTR line in and one IRQRES line out per GPIO pin.
//   Arbitrates pending INTR lines and presents one IRQ and IRQ_ID to the core.
//   On core ACK, drives a clean IRQRES pulse back to the owning GPIO, then confirms INTR dropped.
//   Sits between the GPIO array and the core interrupt input.
// PARAMETERS
//   N_IRQ       8   number of GPIO interrupt lines
//   ID_W        3   IRQ_ID width, = $clog2(N_IRQ)
//   RES_CYC     2   cycles IRQRES is held high (legal range 1..15)
//   CLR_TMO     8   cycles to wait in WAIT for INTR to drop before flagging ERR (1..255)
// PORTS
//   CLK      in   1      system clock, all logic on posedge
//   RST      in   1      synchronous reset, active-high
//   INTR     in   N_IRQ  level interrupt request from each GPIO, held until that GPIO sees IRQRES
//   MASK     in   N_IRQ  1 = line enabled for arbitration
//   IRQRES   out  N_IRQ  registered reset pulse to each GPIO; at most one bit high at a time
//   IRQ      out  1      registered interrupt request to core
//   IRQ_ID   out  ID_W   index of the line being serviced; valid while IRQ=1
//   ACK      in   1      core acknowledge; sampled only in PEND
//   BUSY     out  1      high in any state other than IDLE
//   ERR      out  1      sticky: a serviced INTR failed to clear within CLR_TMO
//   ERR_ID   out  ID_W   line that caused the most recent ERR set
//   ERR_CLR  in   1      clears ERR; if a set occurs in the same cycle, the set wins
// BEHAVIOUR
//   Reset: state=IDLE; IRQ, IRQRES, ERR, BUSY=0; IRQ_ID and ERR_ID=0; counters=0; RR pointer=0.
//   cand = INTR & MASK. FSM states: IDLE, PEND, RES, WAIT.
//   IDLE: if cand!=0, latch win=arb(cand) into IRQ_ID, set IRQ=1, go to PEND (IRQ high 1 cycle after INTR).
//   PEND: IRQ held high.
//     - If INTR[id]&MASK[id] is 0 -> IDLE, IRQ=0, no IRQRES. This check has priority over ACK.
//     - Else if ACK=1 -> RES: IRQ=0, IRQRES[id]=1 from the next cycle.
//   RES: IRQRES[id] is high for exactly RES_CYC cycles. Then IRQRES=0 and go to WAIT.
//     ACK is ignored here. INTR is not sampled here.
//   WAIT: if INTR[id]==0 -> IDLE. Else count; after CLR_TMO cycles -> ERR=1, ERR_ID=id, go to IDLE.
//     That line may re-arbitrate afterwards.
//   Gaps: IDLE always lasts >=1 cycle between services.
//     This guarantees >=1 low cycle on IRQRES, which the GPIO rising-edge detect needs.
//   GPIO timing: the GPIO clears INTR 2 cycles after IRQRES rises.
//     With RES_CYC>=2, INTR is already low on WAIT entry, so WAIT lasts 1 cycle.
//   ACK outside PEND is ignored. MASK changes take effect on the next arbitration.
//     Clearing MASK[id] in PEND aborts service.
//   Mid-operation RST: all outputs drop at the next edge.
//     A partial IRQRES pulse is legal; the GPIO may or may not clear INTR.
//   Counters are sized to their maximum parameter value and never wrap. Arbitration is 1-hot to binary.
// CONFIGURATION
//   GPIO_IRQ_RR_EN undefined: fixed priority, lowest index wins.
//   GPIO_IRQ_RR_EN defined: round-robin.
//     - Search starts at (last serviced id + 1) mod N_IRQ and wraps. Pointer=0 after reset.
//     - The pointer updates on entry to RES only. Aborted PEND does not advance it.
// TESTING
//   1. Single line: INTR[5]=1, MASK=8'hFF.
//      -> IRQ=1, IRQ_ID=5 next cycle. ACK -> IRQRES[5] high 2 cycles. GPIO model drops INTR.
//      -> back to IDLE, BUSY=0.
//   2. Fixed priority: INTR=8'b1010_0100 held, repeated ACKs.
//      -> service order 2,5,7. Each IRQRES pulse separated by >=1 low cycle.
//   3. RR (GPIO_IRQ_RR_EN): INTR[1] and INTR[6] re-raised after every service.
//      -> IDs alternate 1,6,1,6. Without the macro -> 1,1,1.
//   4. Stuck line: INTR[3] held high through ACK.
//      -> ERR=1, ERR_ID=3 after CLR_TMO=8 cycles in WAIT, then re-served.
//      -> ERR_CLR and re-set in the same cycle keep ERR=1.
//   5. Abort: clear MASK[4] while in PEND for ID 4.
//      -> IRQ=0 next cycle, IRQRES stays 0, no ERR.
//   6. RST asserted on the 1st cycle of RES.
//      -> IRQRES=0, IRQ=0, state IDLE next cycle. A later INTR is serviced normally.

Source files
------------

// File: rtl/gpio_irq_ctrl.sv
// Interrupt responder for a GPIO bank: arbitrates INTR lines, raises IRQ, pulses IRQRES on ACK
// and confirms the line dropped. Define GPIO_IRQ_RR_EN for round-robin arbitration.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no service in flight; arbitrate cand = INTR & MASK
// S_PEND | IRQ high for IRQ_ID; wait for ACK, abort if the line goes away
// S_RES  | IRQRES[IRQ_ID] high for RES_CYC cycles; INTR and ACK ignored
// S_WAIT | wait for INTR[IRQ_ID] to drop, flag ERR after CLR_TMO cycles
module gpio_irq_ctrl #(
    parameter int N_IRQ   = 8,
    parameter int ID_W    = $clog2(N_IRQ),
    parameter int RES_CYC = 2,
    parameter int CLR_TMO = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_IRQ-1:0] INTR,
    input  logic [N_IRQ-1:0] MASK,
    output logic [N_IRQ-1:0] IRQRES,
    output logic             IRQ,
    output logic [ID_W-1:0]  IRQ_ID,
    input  logic             ACK,
    output logic             BUSY,
    output logic             ERR,
    output logic [ID_W-1:0]  ERR_ID,
    input  logic             ERR_CLR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_RES  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         res_cnt;
    logic [3:0]         res_cnt_nxt;
    logic [7:0]         tmo_cnt;
    logic [7:0]         tmo_cnt_nxt;
    logic               irq_nxt;
    logic [N_IRQ-1:0]   irqres_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic               err_set;
    logic               err_nxt;
    logic [ID_W-1:0]    err_id_nxt;

    logic [N_IRQ-1:0]   cand;
    logic [N_IRQ-1:0]   grant;
    logic [ID_W-1:0]    win;
    logic               id_live;
    logic [N_IRQ-1:0]   id_onehot;

    assign cand      = INTR & MASK;
    assign id_live   = INTR[IRQ_ID] & MASK[IRQ_ID];
    assign id_onehot = N_IRQ'(1) << IRQ_ID;
    assign BUSY      = (state != S_IDLE);

`ifdef GPIO_IRQ_RR_EN
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [N_IRQ-1:0] cand_rot;
    logic [N_IRQ-1:0] grant_rot;

    // Rotate so the search start sits at bit 0, isolate lowest set bit, rotate back.
    always_comb begin
        cand_rot = '0;
        grant    = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            cand_rot[i] = cand[(i + int'(rr_ptr)) % N_IRQ];
        end
        grant_rot = cand_rot & (~cand_rot + N_IRQ'(1));
        for (int i = 0; i < N_IRQ; i++) begin
            grant[(i + int'(rr_ptr)) % N_IRQ] = grant_rot[i];
        end
    end
`else
    assign grant = cand & (~cand + N_IRQ'(1));
`endif

    always_comb begin
        win = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (grant[i]) begin
                win = win | ID_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        irq_nxt     = IRQ;
        irqres_nxt  = '0;
        id_nxt      = IRQ_ID;
        res_cnt_nxt = res_cnt;
        tmo_cnt_nxt = tmo_cnt;
        err_set     = 1'b0;
`ifdef GPIO_IRQ_RR_EN
        rr_ptr_nxt  = rr_ptr;
`endif
        unique case (state)
            S_IDLE: begin
                if (|cand) begin
                    state_nxt = S_PEND;
                    irq_nxt   = 1'b1;
                    id_nxt    = win;
                end
            end
            S_PEND: begin
                // A vanished or masked line aborts service even if ACK arrives together.
                if (!id_live) begin
                    state_nxt = S_IDLE;
                    irq_nxt   = 1'b0;
                end else if (ACK) begin
                    state_nxt   = S_RES;
                    irq_nxt     = 1'b0;
                    irqres_nxt  = id_onehot;
                    res_cnt_nxt = 4'(RES_CYC - 1);
`ifdef GPIO_IRQ_RR_EN
                    rr_ptr_nxt  = (IRQ_ID == ID_W'(N_IRQ - 1)) ? '0 : IRQ_ID + ID_W'(1);
`endif
                end
            end
            S_RES: begin
                if (res_cnt == '0) begin
                    state_nxt   = S_WAIT;
                    tmo_cnt_nxt = 8'(CLR_TMO - 1);
                end else begin
                    res_cnt_nxt = res_cnt - 4'd1;
                    irqres_nxt  = id_onehot;
                end
            end
            S_WAIT: begin
                if (!INTR[IRQ_ID]) begin
                    state_nxt = S_IDLE;
                end else if (tmo_cnt == '0) begin
                    state_nxt = S_IDLE;
                    err_set   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A set in the same cycle as ERR_CLR leaves ERR high.
    assign err_nxt    = err_set | (ERR & ~ERR_CLR);
    assign err_id_nxt = err_set ? IRQ_ID : ERR_ID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            IRQ     <= 1'b0;
            IRQRES  <= '0;
            IRQ_ID  <= '0;
            ERR     <= 1'b0;
            ERR_ID  <= '0;
            res_cnt <= '0;
            tmo_cnt <= '0;
`ifdef GPIO_IRQ_RR_EN
            rr_ptr  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            IRQ     <= irq_nxt;
            IRQRES  <= irqres_nxt;
            IRQ_ID  <= id_nxt;
            ERR     <= err_nxt;
            ERR_ID  <= err_id_nxt;
            res_cnt <= res_cnt_nxt;
            tmo_cnt <= tmo_cnt_nxt;
`ifdef GPIO_IRQ_RR_EN
            rr_ptr  <= rr_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a service-timeline model of the responder.
module tb_gpio_irq_ctrl;

    localparam int N_IRQ   = 8;
    localparam int ID_W    = 3;
    localparam int RES_CYC = 2;
    localparam int CLR_TMO = 8;
`ifdef GPIO_IRQ_RR_EN
    localparam int RR_ON = 1;
`else
    localparam int RR_ON = 0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [N_IRQ-1:0] INTR;
    logic [N_IRQ-1:0] MASK;
    logic [N_IRQ-1:0] IRQRES;
    logic             IRQ;
    logic [ID_W-1:0]  IRQ_ID;
    logic             ACK;
    logic             BUSY;
    logic             ERR;
    logic [ID_W-1:0]  ERR_ID;
    logic             ERR_CLR;

    gpio_irq_ctrl #(
        .N_IRQ(N_IRQ), .ID_W(ID_W), .RES_CYC(RES_CYC), .CLR_TMO(CLR_TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .INTR(INTR), .MASK(MASK), .IRQRES(IRQRES), .IRQ(IRQ),
        .IRQ_ID(IRQ_ID), .ACK(ACK), .BUSY(BUSY), .ERR(ERR), .ERR_ID(ERR_ID), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a service is a timeline. age<0 means waiting for ACK; age counts cycles since ACK,
    // the first RES_CYC of them carry the reset pulse, the rest are the drop-confirmation window.
    bit m_svc    = 1'b0;
    int m_sid    = 0;
    int m_age    = -1;
    bit m_err    = 1'b0;
    int m_err_id = 0;
    int m_rr     = 0;

    function automatic int model_arb(input logic [N_IRQ-1:0] c, input int start);
        for (int k = 0; k < N_IRQ; k++) begin
            int j;
            j = (start * RR_ON + k) % N_IRQ;
            if (c[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic exp_irq();
        return m_svc && (m_age < 0);
    endfunction

    function automatic logic [N_IRQ-1:0] exp_res();
        logic [N_IRQ-1:0] r;
        r = '0;
        if (m_svc && m_age >= 0 && m_age < RES_CYC) r[m_sid] = 1'b1;
        return r;
    endfunction

    always @(posedge CLK) begin
        bit set_now;
        set_now = 1'b0;
        if (RST) begin
            m_svc = 1'b0; m_age = -1; m_err = 1'b0; m_err_id = 0; m_rr = 0; m_sid = 0;
        end else begin
            if (!m_svc) begin
                if ((INTR & MASK) != '0) begin
                    m_sid = model_arb(INTR & MASK, m_rr);
                    m_svc = 1'b1;
                    m_age = -1;
                end
            end else if (m_age < 0) begin
                if (!(INTR[m_sid] && MASK[m_sid])) m_svc = 1'b0;
                else if (ACK) begin
                    m_age = 0;
                    m_rr  = (m_sid + 1) % N_IRQ;
                end
            end else if (m_age < RES_CYC) begin
                m_age++;
            end else if (!INTR[m_sid]) begin
                m_svc = 1'b0;
            end else if (m_age - RES_CYC + 1 >= CLR_TMO) begin
                set_now  = 1'b1;
                m_err_id = m_sid;
                m_svc    = 1'b0;
            end else begin
                m_age++;
            end
            if (set_now) m_err = 1'b1;
            else if (ERR_CLR) m_err = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            check("cmp_irq", 32'(IRQ), 32'(exp_irq()));
            check("cmp_irqres", 32'(IRQRES), 32'(exp_res()));
            check("cmp_busy", 32'(BUSY), 32'(m_svc));
            check("cmp_err", 32'(ERR), 32'(m_err));
            check("cmp_err_id", 32'(ERR_ID), 32'(m_err_id));
            if (exp_irq()) check("cmp_irq_id", 32'(IRQ_ID), 32'(m_sid));
        end
    end

    // GPIO side: INTR drops two cycles after IRQRES rises unless the line is held stuck.
    logic [N_IRQ-1:0] stuck;
    logic [N_IRQ-1:0] prev_res;
    int               cd [N_IRQ];

    task automatic clear_gpio();
        INTR = '0;
        for (int i = 0; i < N_IRQ; i++) cd[i] = 0;
    endtask

    task automatic tick();
        logic [N_IRQ-1:0] r;
        @(posedge CLK);
        #1;
        r = exp_res();
        for (int i = 0; i < N_IRQ; i++) begin
            if (cd[i] > 0) begin
                cd[i]--;
                if (cd[i] == 0 && !stuck[i]) INTR[i] = 1'b0;
            end
            if (r[i] && !prev_res[i]) cd[i] = 2;
        end
        prev_res = r;
    endtask

    task automatic wait_irq(input int lim);
        int n;
        n = 0;
        while (!IRQ && n < lim) begin
            tick();
            n++;
        end
        check("wait_irq", 32'(IRQ), 32'd1);
    endtask

    task automatic serve_one(output int id);
        int n;
        wait_irq(20);
        id  = int'(IRQ_ID);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        n = 0;
        while (BUSY && n < 40) begin
            tick();
            n++;
        end
        check("serve_done", 32'(BUSY), 32'd0);
    endtask

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int n;
        int exp2 [3];
        int exp3 [4];
        exp2 = '{2, 5, 7};
        if (RR_ON != 0) exp3 = '{1, 6, 1, 6};
        else            exp3 = '{1, 1, 1, 1};

        RST = 1'b1; MASK = '1; ACK = 1'b0; ERR_CLR = 1'b0; stuck = '0; prev_res = '0;
        clear_gpio();
        tick();
        check_en = 1'b1;
        tick();
        check("rst_irq", 32'(IRQ), 32'd0);
        check("rst_irq_id", 32'(IRQ_ID), 32'd0);
        check("rst_irqres", 32'(IRQRES), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_err_id", 32'(ERR_ID), 32'd0);
        RST = 1'b0;
        tick();

        // single line
        INTR[5] = 1'b1;
        tick();
        check("t1_irq", 32'(IRQ), 32'd1);
        check("t1_id", 32'(IRQ_ID), 32'd5);
        ACK = 1'b1; tick(); ACK = 1'b0;
        check("t1_res1", 32'(IRQRES), 32'h20);
        check("t1_irq_low", 32'(IRQ), 32'd0);
        tick();
        check("t1_res2", 32'(IRQRES), 32'h20);
        tick();
        check("t1_res_off", 32'(IRQRES), 32'd0);
        tick();
        check("t1_idle", 32'(BUSY), 32'd0);

        // fixed order over held lines
        INTR = 8'b1010_0100;
        for (int k = 0; k < 3; k++) begin
            serve_one(id);
            check("t2_order", 32'(id), 32'(exp2[k]));
        end
        clear_gpio();
        tick();

        // re-raised pair
        for (int k = 0; k < 4; k++) begin
            INTR[1] = 1'b1;
            INTR[6] = 1'b1;
            serve_one(id);
            check("t3_order", 32'(id), 32'(exp3[k]));
        end
        clear_gpio();
        tick(); tick(); tick();

        // stuck line
        stuck[3] = 1'b1;
        INTR[3]  = 1'b1;
        wait_irq(10);
        check("t4_id", 32'(IRQ_ID), 32'd3);
        ACK = 1'b1; tick(); ACK = 1'b0;
        n = 0;
        while (!ERR && n < 40) begin
            tick();
            n++;
        end
        check("t4_cycles", 32'(n), 32'(RES_CYC + CLR_TMO));
        check("t4_err_id", 32'(ERR_ID), 32'd3);
        check("t4_busy", 32'(BUSY), 32'd0);
        wait_irq(10);
        check("t4_reserve", 32'(IRQ_ID), 32'd3);
        ACK = 1'b1; tick(); ACK = 1'b0;
        for (int k = 0; k < RES_CYC + CLR_TMO - 1; k++) tick();
        ERR_CLR = 1'b1;
        tick();
        check("t4_set_wins", 32'(ERR), 32'd1);
        tick();
        ERR_CLR = 1'b0;
        check("t4_clr", 32'(ERR), 32'd0);
        stuck = '0;
        clear_gpio();
        tick(); tick();

        // abort by mask
        INTR[4] = 1'b1;
        wait_irq(10);
        check("t5_id", 32'(IRQ_ID), 32'd4);
        MASK[4] = 1'b0;
        tick();
        check("t5_irq", 32'(IRQ), 32'd0);
        check("t5_irqres", 32'(IRQRES), 32'd0);
        check("t5_busy", 32'(BUSY), 32'd0);
        check("t5_err", 32'(ERR), 32'd0);
        MASK = '1;
        serve_one(id);
        check("t5_reserve", 32'(id), 32'd4);

        // reset during pulse
        INTR[0] = 1'b1;
        wait_irq(10);
        ACK = 1'b1; tick(); ACK = 1'b0;
        check("t6_res_on", 32'(IRQRES), 32'h01);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_irqres", 32'(IRQRES), 32'd0);
        check("t6_irq", 32'(IRQ), 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
        clear_gpio();
        tick(); tick();
        INTR[2] = 1'b1;
        serve_one(id);
        check("t6_after", 32'(id), 32'd2);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (!INTR[i] && $urandom_range(0, 15) == 0) INTR[i] = 1'b1;
            end
            ACK     = ($urandom_range(0, 2) == 0);
            ERR_CLR = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 40) == 0) MASK = N_IRQ'($urandom);
            if ($urandom_range(0, 60) == 0) MASK = '1;
            if ($urandom_range(0, 200) == 0) stuck = N_IRQ'(1) << $urandom_range(0, N_IRQ - 1);
            if ($urandom_range(0, 150) == 0) stuck = '0;
            RST = ($urandom_range(0, 700) == 0);
            tick();
        end
        RST = 1'b0; ACK = 1'b0; ERR_CLR = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
